univ_mod_counter: RTL and testbench
===================================

Name: univ_mod_counter

Overview:
Parametrised successor to the team's universal up/down binary counter. Adds programmable lower/upper bounds, a programmable step size, and three boundary modes: wrap, saturate, and bounce (ping-pong). It also flags boundary events with a registered pulse. It serves as a general timebase, address sequencer or sweep generator inside larger datapaths, and supports synchronous clear and parallel load.

Parameters:
N, 8, counter/bound/step width in bits

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
syn_clr  input  1  synchronous clear to lo
load  input  1  synchronous parallel load of d
en  input  1  count enable
up  input  1  direction in wrap/saturate modes (1=up, 0=down)
mode  input  2  00 wrap, 01 saturate, 10 bounce, 11 reserved (behaves as wrap)
step  input  N  increment/decrement magnitude, unsigned
lo  input  N  lower bound, unsigned
hi  input  N  upper bound, unsigned
d  input  N  load value
q  output  N  counter value, registered
dir  output  1  registered current direction (1=up)
max_tick  output  1  combinational, q==hi
min_tick  output  1  combinational, q==lo
bound_tick  output  1  registered one-cycle pulse on a boundary event
cfg_err  output  1  combinational, lo>hi

Behaviour:
- Reset (async, active-high): q=0, dir=1, bound_tick=0. Reset mid-operation aborts immediately.
- Synchronous priority per rising edge: syn_clr > load > counting step (en & ~cfg_err) > hold.
- syn_clr: q<=lo, dir<=up, bound_tick<=0.
- load: q<=d, dir<=up, bound_tick<=0. Out-of-range d (outside [lo,hi]) is accepted unchanged.
- Effective direction: the up input in wrap/saturate/reserved modes; the dir register in bounce mode, where the up input is ignored except on load/syn_clr.
- In wrap/saturate modes, dir tracks up every cycle.
- Arithmetic is done at N+1 bits:
  - up: s = {0,q} + {0,step}
  - down: s = {0,q} - {0,step}; a borrow (s[N]=1) counts as below lo.
- Up step, wrap: if s > hi, q<=lo and event; else q<=s[N-1:0].
- Up step, saturate: if s > hi, q<=hi and event; else q<=s.
- Up step, bounce: if s >= hi, q<=hi, dir<=0 and event; else q<=s.
- Down step, wrap: if s < lo or borrow, q<=hi and event; else q<=s.
- Down step, saturate: if s < lo or borrow, q<=lo and event; else q<=s.
- Down step, bounce: if s <= lo or borrow, q<=lo, dir<=1 and event; else q<=s.
- Wrap drops the residual; no modulo remainder is carried.
- bound_tick=1 in the cycle after an event step, otherwise 0. Saturate mode held at a bound with en=1 raises an event on every step.
- step=0: q holds; an event occurs only per the comparisons above (e.g. bounce with q==hi going up).
- cfg_err=1: counting steps are suppressed, q and dir hold, bound_tick=0. load and syn_clr still act.
- mode changes take effect on the next step. No state is cleared on a mode change.

Test Plan:
- Reset/priority: assert reset mid-count -> q=0, dir=1, bound_tick=0 immediately. Then syn_clr=1 with load=1, lo=7, d=99 -> q=7.
- Wrap up (N=8): lo=10, hi=20, step=3, en=1, up=1, start q=10 -> q=13,16,19,10. bound_tick=1 only in the cycle after q becomes 10; max_tick never set.
- Saturate down: lo=5, hi=50, step=4, load d=12, up=0 -> q=8,5,5,5. bound_tick=1 following each step after 8; min_tick=1 from q=5.
- Bounce: mode=10, lo=0, hi=6, step=2, syn_clr with up=1, then en -> q=2,4,6,4,2,0,2. dir falls when q=6 and rises when q=0; bound_tick pulses after the 6 and 0 steps.
- Full-width overflow/borrow: hi=255, lo=0, q=250, step=10, wrap up -> q=0 with event. Then down from q=3, step=10 -> q=255 with event.
- cfg_err and reserved mode: lo=30, hi=20, en=1 -> cfg_err=1, q holds, load d=40 still gives q=40. Then mode=11, lo=0, hi=3, step=1 from q=3 -> q=0 (wrap).

Source files
------------

// File: rtl/univ_mod_counter.sv
// ---------------------------------------------------------------------------
// univ_mod_counter
//   Universal modulo counter with programmable lower/upper bounds, a
//   programmable step size and three boundary modes:
//     00 wrap     - crossing a bound reloads the opposite bound
//     01 saturate - crossing a bound clamps to that bound
//     10 bounce   - reaching a bound clamps and reverses direction
//     11 reserved - behaves as wrap
//   Boundary events are reported with a registered one-cycle pulse.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   syn_clr    synchronous clear to lo (highest synchronous priority)
//   load       synchronous parallel load of d
//   en         count enable
//   up         direction in wrap/saturate modes (1 = up)
//   mode       boundary mode (see above)
//   step       unsigned step magnitude
//   lo, hi     unsigned lower / upper bound
//   d          load value
//   q          registered counter value
//   dir        registered current direction (1 = up)
//   max_tick   q == hi (combinational)
//   min_tick   q == lo (combinational)
//   bound_tick registered pulse in the cycle after a boundary event
//   cfg_err    lo > hi (combinational); suppresses counting
// ---------------------------------------------------------------------------
module univ_mod_counter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         syn_clr,
  input  logic         load,
  input  logic         en,
  input  logic         up,
  input  logic [1:0]   mode,
  input  logic [N-1:0] step,
  input  logic [N-1:0] lo,
  input  logic [N-1:0] hi,
  input  logic [N-1:0] d,
  output logic [N-1:0] q,
  output logic         dir,
  output logic         max_tick,
  output logic         min_tick,
  output logic         bound_tick,
  output logic         cfg_err
);

  localparam logic [1:0] MODE_SAT    = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;

  logic [N-1:0] q_r, q_s;
  logic         dir_r, dir_s;
  logic         tick_r, tick_s;

  logic [N:0]   sum_s, diff_s, hi_x_s, lo_x_s;
  logic         bounce_s, eff_up_s, cfg_err_s;
  logic         over_s, reach_hi_s, under_s, reach_lo_s;

  // Arithmetic one bit wider than the counter so an overflow or borrow is
  // never mistaken for an in-range result.
  assign sum_s  = {1'b0, q_r} + {1'b0, step};
  assign diff_s = {1'b0, q_r} - {1'b0, step};
  assign hi_x_s = {1'b0, hi};
  assign lo_x_s = {1'b0, lo};

  // A borrow (diff_s[N]) always counts as having gone below lo.
  assign over_s     = (sum_s > hi_x_s);
  assign reach_hi_s = (sum_s >= hi_x_s);
  assign under_s    = diff_s[N] || (diff_s < lo_x_s);
  assign reach_lo_s = diff_s[N] || (diff_s <= lo_x_s);

  assign bounce_s  = (mode == MODE_BOUNCE);
  assign cfg_err_s = (lo > hi);
  // Bounce follows its own direction register; other modes follow up.
  assign eff_up_s  = bounce_s ? dir_r : up;

  // Next-state selection: syn_clr > load > counting step > hold.
  always_comb begin
    q_s    = q_r;
    dir_s  = dir_r;
    tick_s = 1'b0;
    if (syn_clr) begin
      q_s   = lo;
      dir_s = up;
    end else if (load) begin
      q_s   = d;
      dir_s = up;
    end else if (en && !cfg_err_s) begin
      if (!bounce_s) begin
        dir_s = up;
      end else begin
        dir_s = dir_r;
      end
      if (eff_up_s) begin
        case (mode)
          MODE_SAT: begin
            if (over_s) begin
              q_s    = hi;
              tick_s = 1'b1;
            end else begin
              q_s = sum_s[N-1:0];
            end
          end
          MODE_BOUNCE: begin
            if (reach_hi_s) begin
              q_s    = hi;
              dir_s  = 1'b0;
              tick_s = 1'b1;
            end else begin
              q_s = sum_s[N-1:0];
            end
          end
          default: begin
            if (over_s) begin
              q_s    = lo;
              tick_s = 1'b1;
            end else begin
              q_s = sum_s[N-1:0];
            end
          end
        endcase
      end else begin
        case (mode)
          MODE_SAT: begin
            if (under_s) begin
              q_s    = lo;
              tick_s = 1'b1;
            end else begin
              q_s = diff_s[N-1:0];
            end
          end
          MODE_BOUNCE: begin
            if (reach_lo_s) begin
              q_s    = lo;
              dir_s  = 1'b1;
              tick_s = 1'b1;
            end else begin
              q_s = diff_s[N-1:0];
            end
          end
          default: begin
            if (under_s) begin
              q_s    = hi;
              tick_s = 1'b1;
            end else begin
              q_s = diff_s[N-1:0];
            end
          end
        endcase
      end
    end else begin
      // Idle: direction still tracks up outside bounce unless the bounds
      // are inconsistent, in which case everything holds.
      if (!bounce_s && !cfg_err_s) begin
        dir_s = up;
      end else begin
        dir_s = dir_r;
      end
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_r    <= {N{1'b0}};
      dir_r  <= 1'b1;
      tick_r <= 1'b0;
    end else begin
      q_r    <= q_s;
      dir_r  <= dir_s;
      tick_r <= tick_s;
    end
  end

  assign q          = q_r;
  assign dir        = dir_r;
  assign bound_tick = tick_r;
  assign max_tick   = (q_r == hi);
  assign min_tick   = (q_r == lo);
  assign cfg_err    = cfg_err_s;

endmodule

// File: tb/tb_univ_mod_counter.sv
// ---------------------------------------------------------------------------
// tb_univ_mod_counter
//   Self-checking bench for univ_mod_counter (N = 8). Directed scenarios
//   compare against hand-derived constants and an integer reference model;
//   a randomized phase compares every cycle against the same model.
// ---------------------------------------------------------------------------
module tb_univ_mod_counter;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         syn_clr, load, en, up;
  logic [1:0]   mode;
  logic [N-1:0] step, lo, hi, d;
  logic [N-1:0] q;
  logic         dir, max_tick, min_tick, bound_tick, cfg_err;
  logic [12:0]  dut_vec;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state (plain integers).
  int m_q;
  bit m_dir;
  bit m_tick;

  univ_mod_counter #(.N(N)) dut (
    .clk(clk), .reset(reset), .syn_clr(syn_clr), .load(load), .en(en),
    .up(up), .mode(mode), .step(step), .lo(lo), .hi(hi), .d(d),
    .q(q), .dir(dir), .max_tick(max_tick), .min_tick(min_tick),
    .bound_tick(bound_tick), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  assign dut_vec = {q, dir, bound_tick, max_tick, min_tick, cfg_err};

  // Reference model: apply one clock edge's worth of behaviour.
  task automatic model_update();
    int s, h, l;
    bit eu;
    h = hi;
    l = lo;
    if (syn_clr) begin
      m_q = l; m_dir = up; m_tick = 1'b0;
    end else if (load) begin
      m_q = d; m_dir = up; m_tick = 1'b0;
    end else if (en && !(l > h)) begin
      eu = (mode == 2'd2) ? m_dir : up;
      m_tick = 1'b0;
      if (mode != 2'd2) m_dir = up;
      if (eu) begin
        s = m_q + int'(step);
        if (mode == 2'd1) begin
          if (s > h) begin m_q = h; m_tick = 1'b1; end else m_q = s;
        end else if (mode == 2'd2) begin
          if (s >= h) begin m_q = h; m_dir = 1'b0; m_tick = 1'b1; end else m_q = s;
        end else begin
          if (s > h) begin m_q = l; m_tick = 1'b1; end else m_q = s;
        end
      end else begin
        s = m_q - int'(step);
        if (mode == 2'd1) begin
          if (s < l) begin m_q = l; m_tick = 1'b1; end else m_q = s;
        end else if (mode == 2'd2) begin
          if (s <= l) begin m_q = l; m_dir = 1'b1; m_tick = 1'b1; end else m_q = s;
        end else begin
          if (s < l) begin m_q = h; m_tick = 1'b1; end else m_q = s;
        end
      end
    end else begin
      m_tick = 1'b0;
      if (mode != 2'd2 && !(l > h)) m_dir = up;
    end
  endtask

  function automatic logic [12:0] model_vec();
    int h, l;
    h = hi;
    l = lo;
    return {8'(m_q), m_dir, m_tick, (m_q == h), (m_q == l), (l > h)};
  endfunction

  task automatic model_reset();
    m_q = 0; m_dir = 1'b1; m_tick = 1'b0;
  endtask

  // One clock edge; outputs are sampled 1 time unit after the edge.
  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; syn_clr = 1'b0; load = 1'b0; en = 1'b0; up = 1'b1;
    mode = 2'd0; step = 8'd1; lo = 8'd0; hi = 8'd255; d = 8'd0;
    model_reset();
    #12 reset = 1'b0;
    n_cmp++;
    if (dut_vec !== model_vec() || q !== 8'd0 || dir !== 1'b1) begin
      n_fail++; $display("FAIL reset_init got %h want %h", dut_vec, model_vec());
    end
    // Count down from 0: borrow wraps to 255 with an event, dir follows up=0.
    en = 1'b1; up = 1'b0;
    cycle();
    n_cmp++;
    if (q !== 8'd255 || dir !== 1'b0 || bound_tick !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset got q=%0d dir=%b tick=%b want 255 0 1", q, dir, bound_tick);
    end
    #2 reset = 1'b1;
    #1;
    model_reset();
    n_cmp++;
    if (q !== 8'd0 || dir !== 1'b1 || bound_tick !== 1'b0) begin
      n_fail++; $display("FAIL async_reset got q=%0d dir=%b tick=%b want 0 1 0", q, dir, bound_tick);
    end
    #1 reset = 1'b0;
    en = 1'b0; up = 1'b1; syn_clr = 1'b1; load = 1'b1; lo = 8'd7; hi = 8'd200; d = 8'd99;
    cycle();
    n_cmp++;
    if (q !== 8'd7 || dut_vec !== model_vec()) begin
      n_fail++; $display("FAIL clr_priority got q=%0d want 7", q);
    end
    syn_clr = 1'b0; load = 1'b0;
  endtask

  task automatic test_wrap();
    int exp_q [4] = '{13, 16, 19, 10};
    bit exp_t [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    mode = 2'd0; lo = 8'd10; hi = 8'd20; step = 8'd3; up = 1'b1; en = 1'b0;
    load = 1'b1; d = 8'd10;
    cycle();
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_cmp++;
      if (q !== 8'(exp_q[i]) || bound_tick !== exp_t[i] || max_tick !== 1'b0 ||
          dut_vec !== model_vec()) begin
        n_fail++;
        $display("FAIL wrap[%0d] got q=%0d tick=%b max=%b want q=%0d tick=%b max=0",
                 i, q, bound_tick, max_tick, exp_q[i], exp_t[i]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_saturate();
    int exp_q [4] = '{8, 5, 5, 5};
    bit exp_t [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    mode = 2'd1; lo = 8'd5; hi = 8'd50; step = 8'd4; up = 1'b0; en = 1'b0;
    load = 1'b1; d = 8'd12;
    cycle();
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_cmp++;
      if (q !== 8'(exp_q[i]) || bound_tick !== exp_t[i] || min_tick !== (i > 0) ||
          dut_vec !== model_vec()) begin
        n_fail++;
        $display("FAIL sat[%0d] got q=%0d tick=%b min=%b want q=%0d tick=%b",
                 i, q, bound_tick, min_tick, exp_q[i], exp_t[i]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_bounce();
    int exp_q [7] = '{2, 4, 6, 4, 2, 0, 2};
    bit exp_d [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    bit exp_t [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    mode = 2'd2; lo = 8'd0; hi = 8'd6; step = 8'd2; up = 1'b1; en = 1'b0;
    syn_clr = 1'b1;
    cycle();
    // up is ignored while bouncing.
    syn_clr = 1'b0; en = 1'b1; up = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cycle();
      n_cmp++;
      if (q !== 8'(exp_q[i]) || dir !== exp_d[i] || bound_tick !== exp_t[i] ||
          dut_vec !== model_vec()) begin
        n_fail++;
        $display("FAIL bounce[%0d] got q=%0d dir=%b tick=%b want q=%0d dir=%b tick=%b",
                 i, q, dir, bound_tick, exp_q[i], exp_d[i], exp_t[i]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_overflow();
    mode = 2'd0; lo = 8'd0; hi = 8'd255; step = 8'd10; up = 1'b1; en = 1'b0;
    load = 1'b1; d = 8'd250;
    cycle();
    load = 1'b0; en = 1'b1;
    cycle();
    n_cmp++;
    if (q !== 8'd0 || bound_tick !== 1'b1 || dut_vec !== model_vec()) begin
      n_fail++; $display("FAIL overflow got q=%0d tick=%b want 0 1", q, bound_tick);
    end
    en = 1'b0; up = 1'b0; load = 1'b1; d = 8'd3;
    cycle();
    load = 1'b0; en = 1'b1;
    cycle();
    n_cmp++;
    if (q !== 8'd255 || bound_tick !== 1'b1 || dut_vec !== model_vec()) begin
      n_fail++; $display("FAIL borrow got q=%0d tick=%b want 255 1", q, bound_tick);
    end
    en = 1'b0;
  endtask

  task automatic test_cfg_err();
    mode = 2'd0; lo = 8'd30; hi = 8'd20; step = 8'd1; up = 1'b1; en = 1'b1;
    #1;
    n_cmp++;
    if (cfg_err !== 1'b1) begin
      n_fail++; $display("FAIL cfg_err_flag got %b want 1", cfg_err);
    end
    for (int i = 0; i < 2; i++) begin
      cycle();
      n_cmp++;
      if (q !== 8'd255 || bound_tick !== 1'b0 || dir !== 1'b0 || dut_vec !== model_vec()) begin
        n_fail++; $display("FAIL cfg_hold[%0d] got q=%0d dir=%b tick=%b want 255 0 0", i, q, dir, bound_tick);
      end
    end
    load = 1'b1; d = 8'd40;
    cycle();
    n_cmp++;
    if (q !== 8'd40 || dut_vec !== model_vec()) begin
      n_fail++; $display("FAIL cfg_load got q=%0d want 40", q);
    end
    mode = 2'd3; lo = 8'd0; hi = 8'd3; step = 8'd1; d = 8'd3;
    cycle();
    load = 1'b0;
    cycle();
    n_cmp++;
    if (q !== 8'd0 || bound_tick !== 1'b1 || cfg_err !== 1'b0 || dut_vec !== model_vec()) begin
      n_fail++; $display("FAIL reserved_wrap got q=%0d tick=%b err=%b want 0 1 0", q, bound_tick, cfg_err);
    end
    en = 1'b0;
  endtask

  task automatic test_random();
    int t;
    for (int i = 0; i < 600; i++) begin
      if (i % 16 == 0) begin
        mode = 2'($urandom_range(0, 3));
        lo   = 8'($urandom_range(0, 100));
        hi   = 8'(int'(lo) + int'($urandom_range(0, 155)));
        if ($urandom_range(0, 7) == 0) begin
          t = lo; lo = hi; hi = 8'(t);
        end
        step = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                           : 8'($urandom_range(0, 12));
      end
      syn_clr = ($urandom_range(0, 39) == 0);
      load    = ($urandom_range(0, 19) == 0);
      en      = ($urandom_range(0, 3) != 0);
      up      = 1'($urandom_range(0, 1));
      d       = 8'($urandom_range(0, 255));
      cycle();
      n_cmp++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("FAIL random[%0d] got {q,dir,tick,max,min,err}=%h want %h mode=%0d lo=%0d hi=%0d step=%0d",
                 i, dut_vec, model_vec(), mode, lo, hi, step);
      end
    end
    syn_clr = 1'b0; load = 1'b0; en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_saturate();
    test_bounce();
    test_overflow();
    test_cfg_err();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
